clk_int_div: RTL
================

# clk_int_div

Parametrised integer clock divider; generational successor to the even-only simple divider. Divides `clk_i` by any integer N ≥ 2 (even or odd), with a run-time divisor update over a valid/ready handshake. Updates are applied only at an output-period boundary, so `clk_o` never glitches. Sits in the clock/reset utility layer and feeds peripheral clocks (UART, SPI, timers) from the system clock.

## Interface
- `DIV_WIDTH`, default 8: width of the divisor and the internal counter; maximum N = 2^DIV_WIDTH − 1.
- `DIV_RST`, default 4: active divisor after reset; must be in the range 2 to 2^DIV_WIDTH − 1.
- `clk_i`  in  1  source clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  divider enable; when low, `clk_o` is held low.
- `div_i`  in  DIV_WIDTH  requested divisor N.
- `div_valid_i`  in  1  `div_i` is valid.
- `div_ready_o`  out  1  block can accept a new divisor.
- `done_o`  out  1  one-cycle pulse in the cycle the new divisor takes effect.
- `clk_o`  out  1  divided clock.

## Operation
- Registers:
  - `div_q` (active N), `pend_q` (pending N), `pend_vld_q`.
  - `cnt_q` (DIV_WIDTH bits), `pos_q` (posedge phase), `neg_q` (negedge phase, macro only).
- Reset values:
  - `div_q` = DIV_RST; `cnt_q` = DIV_RST − 1; `pos_q` = `neg_q` = 0.
  - `pend_vld_q` = 0; `div_ready_o` = 1; `done_o` = 0; `clk_o` = 0.
- High-phase length H = floor(N/2), where N = `div_q`.
- Counting, each posedge `clk_i` with `en_i` = 1:
  - `cnt_q` ← 0 if `cnt_q` == N − 1, else `cnt_q` + 1.
  - `pos_q` ← (next `cnt_q` < H).
- Output: `clk_o` = `pos_q` (even N, or macro disabled).
- Clamp: `div_i` values 0 and 1 are stored as 2. No bypass mode exists.
- Handshake:
  - A transfer occurs on a posedge with `div_valid_i` & `div_ready_o`.
  - On transfer: `pend_q` ← clamped `div_i`, `pend_vld_q` ← 1.
  - `div_ready_o` = !`pend_vld_q`, so only one update is outstanding at a time.
- Apply, on a posedge with `pend_vld_q` = 1 and either `cnt_q` == N − 1 (wrap) or `en_i` = 0:
  - `div_q` ← `pend_q`; `pend_vld_q` ← 0; `done_o` ← 1 for one cycle.
  - At a wrap with `en_i` = 1: `cnt_q` ← 0 and `pos_q` ← 1, so the new period starts immediately with no runt pulse.
  - With `en_i` = 0: `cnt_q` ← `pend_q` − 1.
- `en_i` = 0: `cnt_q` is held at N − 1 and `pos_q`/`neg_q` at 0. The first posedge after `en_i` rises starts a high phase.
- Same-divisor write (new N equal to current N): the handshake still completes and `done_o` still pulses; the period is unchanged.
- Reset asserted mid-period: all registers return to reset values asynchronously, `clk_o` falls immediately, and any pending divisor is discarded.

## Timing
- A request with `div_valid_i` held high is accepted on the first posedge where `div_ready_o` = 1. `div_ready_o` drops the following cycle.
- Apply latency from accept: 1 to N cycles (the next wrap).
- `done_o` is registered and asserts on the cycle after the apply edge. `div_ready_o` returns high in that same cycle.
- A new request may be accepted in the cycle `done_o` is high.
- `clk_o` toggles only from flop outputs (`pos_q` or `pos_q` | `neg_q`), so no combinational clock path exists.
- The first `clk_o` rising edge occurs at the first posedge after reset release, with `en_i` = 1.
- `div_valid_i` dropped before acceptance: no state change.

## Configuration
- `CLK_INT_DIV_ODD_DUTY_EN` defined:
  - Adds `neg_q`, which samples `pos_q` on negedge `clk_i` (same async reset).
  - For odd N, `clk_o` = `pos_q` | `neg_q`: high for N/2 source cycles, i.e. exact 50 % duty.
  - For even N, `clk_o` = `pos_q`.
- Macro undefined:
  - No negedge flop is present.
  - For odd N, `clk_o` = `pos_q`: high floor(N/2) cycles, low ceil(N/2) cycles.

## Test plan
- Reset, `en_i` = 1, 10 ns `clk_i` -> `clk_o` period 40 ns, high 20 ns. `div_ready_o` = 1 and `done_o` = 0 throughout.
- Write N = 3 -> period 30 ns:
  - With `CLK_INT_DIV_ODD_DUTY_EN`: high 15 ns.
  - Without the macro: high 10 ns, low 20 ns.
- Write N = 6 while counting at N = 4 -> `div_ready_o` low until the wrap. `done_o` pulses once. The first new period is high 30 ns / low 30 ns, with no short pulse at the boundary.
- Write N = 0, then N = 1 -> each is clamped to 2: period 20 ns, high 10 ns. Each write produces one `done_o` pulse.
- `en_i` low for 50 cycles while writing N = 5 -> `clk_o` stays 0 and `done_o` pulses within 1 cycle of the apply. On `en_i` rising, `clk_o` rises at the next posedge with period 50 ns.
- Assert `rst_n_i` mid-high-phase with an update pending -> `clk_o` drops immediately. After release: N = 4 restored, `div_ready_o` = 1, and no `done_o` pulse.

Source files
------------

// File: rtl/clk_int_div.sv
// clk_int_div: integer clock divider, N >= 2 (even or odd), with a run-time
// divisor update over a valid/ready handshake. A new divisor is applied only
// at an output-period boundary (or while disabled), so clk_o never glitches.
// Optional macro CLK_INT_DIV_ODD_DUTY_EN adds a negedge phase flop that gives
// odd divisors an exact 50 % duty cycle.
module clk_int_div #(
    parameter int DIV_WIDTH = 8,
    parameter int DIV_RST   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 done_o,
    output logic                 clk_o
);

    localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DIV_RST);
    localparam logic [DIV_WIDTH-1:0] RST_CNT = DIV_WIDTH'(DIV_RST - 1);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] pend_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 pend_vld_q;
    logic                 pos_q;

    logic [DIV_WIDTH-1:0] last;
    logic [DIV_WIDTH-1:0] half;
    logic [DIV_WIDTH-1:0] cnt_nxt;
    logic [DIV_WIDTH-1:0] div_clamp;
    logic                 wrap;

    assign last        = div_q - ONE;
    assign half        = div_q >> 1;
    assign wrap        = (cnt_q == last);
    assign cnt_nxt     = wrap ? '0 : cnt_q + ONE;
    // 0 and 1 are not meaningful divisors; there is no bypass mode
    assign div_clamp   = (div_i < TWO) ? TWO : div_i;
    // only one update may be outstanding at a time
    assign div_ready_o = !pend_vld_q;

    // Counter, posedge phase, handshake capture and boundary-aligned apply
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q      <= RST_DIV;
            pend_q     <= RST_DIV;
            pend_vld_q <= 1'b0;
            cnt_q      <= RST_CNT;
            pos_q      <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (div_valid_i && !pend_vld_q) begin
                pend_q     <= div_clamp;
                pend_vld_q <= 1'b1;
            end
            if (!en_i) begin
                // Parked at N-1 so the first enabled edge wraps into a high phase
                pos_q <= 1'b0;
                if (pend_vld_q) begin
                    div_q      <= pend_q;
                    pend_vld_q <= 1'b0;
                    done_o     <= 1'b1;
                    cnt_q      <= pend_q - ONE;
                end else begin
                    cnt_q <= last;
                end
            end else begin
                cnt_q <= cnt_nxt;
                pos_q <= (cnt_nxt < half);
                if (pend_vld_q && wrap) begin
                    // new period starts right at the wrap: no runt pulse
                    div_q      <= pend_q;
                    pend_vld_q <= 1'b0;
                    done_o     <= 1'b1;
                    pos_q      <= 1'b1;
                end
            end
        end
    end

`ifdef CLK_INT_DIV_ODD_DUTY_EN
    logic neg_q;

    // Half-cycle delayed copy of the posedge phase, stretches odd-N high time
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) neg_q <= 1'b0;
        else          neg_q <= pos_q;
    end

    assign clk_o = div_q[0] ? (pos_q | neg_q) : pos_q;
`else
    assign clk_o = pos_q;
`endif

endmodule
